alu_uart_interface: RTL and testbench
=====================================

# alu_uart_interface

Command sequencer that drives the operand/opcode side of the ALU from a UART byte stream and returns the result over UART. It sits between the UART receiver/transmitter and the ALU in the board top level. It collects three bytes in order (A, B, OP), presents them to the ALU, captures the result one cycle later, and hands the result to the UART transmitter with a start pulse. It then waits for transmit completion before accepting the next command.

## Interface
- DATA_SIZE, 8, operand/result width; equals the UART byte width; must be ≥ 6
- OP_SIZE, 6, ALU opcode width
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  DATA_SIZE  received byte; valid only while i_rx_done=1
- i_rx_done  in  1  one-cycle pulse per received byte
- i_tx_done  in  1  one-cycle pulse when the transmitter finishes a byte
- i_alu_result  in  DATA_SIZE  ALU combinational result
- o_alu_a  out  DATA_SIZE  operand A to ALU (registered)
- o_alu_b  out  DATA_SIZE  operand B to ALU (registered)
- o_alu_op  out  OP_SIZE  opcode to ALU (registered)
- o_tx_data  out  DATA_SIZE  byte to transmit (registered, held until next capture)
- o_tx_start  out  1  one-cycle transmit request
- o_busy  out  1  high in EXEC, SEND, WAIT_TX

## Operation
- Reset values: o_alu_a=0, o_alu_b=0, o_alu_op=0, o_tx_data=0, o_tx_start=0, o_busy=0, state=WAIT_A.
- WAIT_A:
  - i_rx_done=1 → o_alu_a ← i_rx_data; go to WAIT_B.
- WAIT_B:
  - i_rx_done=1 → o_alu_b ← i_rx_data; go to WAIT_OP.
- WAIT_OP:
  - i_rx_done=1 → o_alu_op ← i_rx_data[OP_SIZE-1:0]; go to EXEC.
  - Bits above OP_SIZE are discarded.
- EXEC (1 cycle): o_tx_data ← i_alu_result; go to SEND.
- SEND (1 cycle): o_tx_start=1; go to WAIT_TX.
- WAIT_TX:
  - i_tx_done=1 → go to WAIT_A.
  - Otherwise hold indefinitely; there is no timeout.
- Opcodes are forwarded unchecked.
  - Undefined opcodes produce whatever the ALU returns, which is 0.
  - That value is transmitted like any other result.
- o_alu_a, o_alu_b and o_alu_op hold their values until overwritten by the next command. They are never cleared between commands.
- Boundary rules:
  - i_rx_done in EXEC, SEND or WAIT_TX: the byte is dropped, not buffered.
  - i_tx_done outside WAIT_TX: ignored.
  - i_rx_done and i_tx_done in the same cycle in WAIT_TX: tx_done is taken and the rx byte is dropped. The next command starts with the next received byte.
  - i_reset asserted mid-command, from any state: all outputs clear immediately and the state returns to WAIT_A. A partially received command is discarded.
  - The same operand bytes repeated produce identical behaviour; no sticky state carries between commands.
- No arithmetic is performed here; all widths pass straight through.

## Timing
- All state and outputs update on the rising edge of i_clk, except reset, which acts asynchronously.
- Let edge k be the edge at which i_rx_done=1 is sampled for the OP byte:
  - After edge k: o_alu_op is valid and the state is EXEC.
  - At edge k+1: i_alu_result is captured into o_tx_data.
  - Cycle between edges k+1 and k+2: o_tx_start=1, and o_tx_data is already stable.
  - After edge k+2: o_tx_start=0 and the state is WAIT_TX.
- Latency from the OP byte to the start pulse is 2 cycles.
- o_tx_start is never high for more than one cycle per command.
- o_tx_data is stable from edge k+1 until the next EXEC.
- o_busy is high from the edge entering EXEC to the edge leaving WAIT_TX.
- Minimum command period = 3 rx pulses + 3 cycles + transmitter time.

## Structure
- Shared include/package contents:
  - ALU opcode localparams (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111).
  - State encodings: 3-bit, WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SEND=4, WAIT_TX=5. Unused codes recover to WAIT_A.
- Single module, no sub-modules.
- Board top instantiates this block, alu, uart_rx and uart_tx side by side.
- Use a two-process FSM: registered state/datapath plus combinational next-state logic.

## Test plan
- Reset mid-command: send A=0x05 and B=0x03, then assert i_reset. Required response: all outputs are 0 without waiting for a clock edge, and the state is WAIT_A. A following command A=0x01, B=0x01, OP=0x20 yields tx 0x02.
- Basic ADD with a real ALU instance: A=0x05, B=0x03, OP=0x20. Required response: o_alu_* = 05/03/20, o_tx_data=0x08, o_tx_start high exactly one cycle, 2 cycles after the OP pulse.
- SRA and SUB: A=0x80, B=0x02, OP=0x03 → tx 0xE0. Then A=0x03, B=0x05, OP=0x22 → tx 0xFE.
- Opcode masking and invalid opcode:
  - OP byte 0xE4 → o_alu_op=0x24 (AND).
  - OP byte 0x3F → tx 0x00, and the handshake still completes.
- Drop while busy: during WAIT_TX inject rx 0xAA, then assert i_tx_done together with rx 0xBB. Required response: both bytes are dropped. The next three bytes 0x02, 0x02, 0x24 yield tx 0x02.
- Back-to-back commands with i_tx_done delayed 1000 cycles. Required response: o_busy stays high throughout, no second o_tx_start is issued, and operands stay stable.

Source files
------------

// File: rtl/alu_uart_interface_pkg.sv
// Shared constants for the UART-driven ALU command sequencer: ALU opcodes
// and sequencer state encodings.
package alu_uart_interface_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    function automatic logic state_is_busy(input logic [2:0] st);
        return (st == ST_EXEC) || (st == ST_SEND) || (st == ST_WAIT_TX);
    endfunction

endpackage

// File: rtl/alu_uart_interface.sv
// Collects A, B, OP bytes from the UART receiver, drives the ALU, and hands
// the captured result to the UART transmitter with a one-cycle start pulse.
module alu_uart_interface
    import alu_uart_interface_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int OP_SIZE   = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATA_SIZE-1:0] i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_tx_done,
    input  logic [DATA_SIZE-1:0] i_alu_result,
    output logic [DATA_SIZE-1:0] o_alu_a,
    output logic [DATA_SIZE-1:0] o_alu_b,
    output logic [OP_SIZE-1:0]   o_alu_op,
    output logic [DATA_SIZE-1:0] o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy
);

    logic [2:0]           state_q, state_d;
    logic [DATA_SIZE-1:0] alu_a_q, alu_a_d;
    logic [DATA_SIZE-1:0] alu_b_q, alu_b_d;
    logic [OP_SIZE-1:0]   alu_op_q, alu_op_d;
    logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;

    // Next-state and datapath selection; bytes arriving outside the WAIT_* states are dropped.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = ST_WAIT_B;
                end else begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = ST_WAIT_OP;
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[OP_SIZE-1:0];
                    state_d  = ST_EXEC;
                end else begin
                    state_d = ST_WAIT_OP;
                end
            end
            ST_EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
        // Status outputs are derived from the upcoming state so they stay registered yet aligned.
        tx_start_d = (state_d == ST_SEND);
        busy_d     = state_is_busy(state_d);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a behavioural ALU closing the loop.
module tb_alu_uart_interface;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_uart_interface #(.DATA_SIZE(8), .OP_SIZE(6)) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .i_alu_result(alu_result),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy)
    );

    // Reference ALU; undefined opcodes return zero.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            6'h03:   alu_result = $signed(alu_a) >>> alu_b;
            6'h02:   alu_result = alu_a >> alu_b;
            6'h27:   alu_result = ~(alu_a | alu_b);
            default: alu_result = 8'h00;
        endcase
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Sends one command and observes the start pulse: start_at counts negedges from the OP pulse.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input bit do_done, output logic [7:0] tx_seen,
                           output int start_at, output int start_len);
        start_at  = -1;
        start_len = 0;
        tx_seen   = 8'hxx;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        if (tx_start) begin
            start_at = 1;
            start_len++;
        end
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (tx_start) begin
                if (start_at < 0) begin
                    start_at = i;
                    tx_seen  = tx_data;
                end
                start_len++;
            end
        end
        if (do_done) pulse_tx_done();
    endtask

    task automatic test_reset();
        logic [7:0] tx; int at; int len;
        rst = 1'b1;
        #2;
        n_checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy} !== 31'h0) begin
            n_fail++;
            $display("FAIL reset_init: got a=%h b=%h op=%h tx=%h st=%b busy=%b want all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h05);
        send_byte(8'h03);
        n_checks++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03) begin
            n_fail++;
            $display("FAIL reset_pre_load: got a=%h b=%h want 05 03", alu_a, alu_b);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy} !== 31'h0) begin
            n_fail++;
            $display("FAIL reset_async: got a=%h b=%h op=%h tx=%h want all 0",
                     alu_a, alu_b, alu_op, tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        run_cmd(8'h01, 8'h01, 8'h20, 1'b1, tx, at, len);
        n_checks++;
        if (tx !== 8'h02 || at !== 2) begin
            n_fail++;
            $display("FAIL reset_recover: got tx=%h at=%0d want 02 at 2", tx, at);
        end
    endtask

    task automatic test_add();
        logic [7:0] tx; int at; int len;
        run_cmd(8'h05, 8'h03, 8'h20, 1'b0, tx, at, len);
        n_checks++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h20) begin
            n_fail++;
            $display("FAIL add_operands: got %h/%h/%h want 05/03/20", alu_a, alu_b, alu_op);
        end
        n_checks++;
        if (tx !== 8'h08 || tx_data !== 8'h08) begin
            n_fail++;
            $display("FAIL add_tx: got %h (held %h) want 08", tx, tx_data);
        end
        n_checks++;
        if (at !== 2 || len !== 1) begin
            n_fail++;
            $display("FAIL add_start: got at=%0d len=%0d want at=2 len=1", at, len);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL add_busy_wait: got %b want 1", busy);
        end
        pulse_tx_done();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy_done: got %b want 0", busy);
        end
    endtask

    task automatic test_sra_sub();
        logic [7:0] tx; int at; int len;
        run_cmd(8'h80, 8'h02, 8'h03, 1'b1, tx, at, len);
        n_checks++;
        if (tx !== 8'hE0 || len !== 1) begin
            n_fail++;
            $display("FAIL sra_tx: got %h len=%0d want E0 len=1", tx, len);
        end
        run_cmd(8'h03, 8'h05, 8'h22, 1'b1, tx, at, len);
        n_checks++;
        if (tx !== 8'hFE || len !== 1) begin
            n_fail++;
            $display("FAIL sub_tx: got %h len=%0d want FE len=1", tx, len);
        end
    endtask

    task automatic test_opcode_mask();
        logic [7:0] tx; int at; int len;
        run_cmd(8'hF0, 8'h3C, 8'hE4, 1'b1, tx, at, len);
        n_checks++;
        if (alu_op !== 6'h24 || tx !== 8'h30) begin
            n_fail++;
            $display("FAIL mask_op: got op=%h tx=%h want 24 30", alu_op, tx);
        end
        run_cmd(8'h12, 8'h34, 8'h3F, 1'b1, tx, at, len);
        n_checks++;
        if (tx !== 8'h00 || at !== 2 || len !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_op: got tx=%h at=%0d len=%0d busy=%b want 00 2 1 0",
                     tx, at, len, busy);
        end
    endtask

    task automatic test_drop_busy();
        logic [7:0] tx; int at; int len;
        run_cmd(8'h01, 8'h01, 8'h20, 1'b0, tx, at, len);
        send_byte(8'hAA);
        @(negedge clk);
        rx_data = 8'hBB;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || alu_a !== 8'h01) begin
            n_fail++;
            $display("FAIL drop_bytes: got busy=%b a=%h want 0 01", busy, alu_a);
        end
        // A stray tx_done while waiting for operands must not disturb collection.
        pulse_tx_done();
        run_cmd(8'h02, 8'h02, 8'h24, 1'b1, tx, at, len);
        n_checks++;
        if (tx !== 8'h02 || alu_a !== 8'h02 || alu_op !== 6'h24) begin
            n_fail++;
            $display("FAIL drop_next_cmd: got tx=%h a=%h op=%h want 02 02 24", tx, alu_a, alu_op);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx; int at; int len;
        int busy_low = 0; int extra_start = 0; int opnd_change = 0;
        run_cmd(8'h0F, 8'hF0, 8'h25, 1'b0, tx, at, len);
        n_checks++;
        if (tx !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_first_tx: got %h want FF", tx);
        end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i % 50 == 10) begin
                rx_data = 8'h40 + 8'(i % 7);
                rx_done = 1'b1;
            end else begin
                rx_done = 1'b0;
            end
            if (busy !== 1'b1) busy_low++;
            if (tx_start !== 1'b0) extra_start++;
            if (alu_a !== 8'h0F || alu_b !== 8'hF0 || alu_op !== 6'h25 || tx_data !== 8'hFF)
                opnd_change++;
        end
        rx_done = 1'b0;
        n_checks++;
        if (busy_low !== 0 || extra_start !== 0 || opnd_change !== 0) begin
            n_fail++;
            $display("FAIL b2b_hold: got busy_low=%0d extra_start=%0d changes=%0d want 0 0 0",
                     busy_low, extra_start, opnd_change);
        end
        pulse_tx_done();
        run_cmd(8'h0F, 8'hF0, 8'h27, 1'b1, tx, at, len);
        n_checks++;
        if (tx !== 8'h00 || alu_op !== 6'h27 || len !== 1) begin
            n_fail++;
            $display("FAIL b2b_second: got tx=%h op=%h len=%0d want 00 27 1", tx, alu_op, len);
        end
        run_cmd(8'h0F, 8'hF0, 8'h26, 1'b1, tx, at, len);
        n_checks++;
        if (tx !== 8'hFF || at !== 2) begin
            n_fail++;
            $display("FAIL b2b_third: got tx=%h at=%0d want FF 2", tx, at);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sra_sub();
        test_opcode_mask();
        test_drop_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
